lbwin2x2: RTL and testbench

Consumer-side companion to the 8-pixel line-buffer memory. It takes the same pixel stream that is written into the line buffer, together with the line buffer's delayed read stream, and forms 2×2 pixel windows: top row from the previous line, bottom row from the current line. It sits directly downstream of the line buffer and feeds stencil/filter stages with registered windows and row/column tags.

---
 rtl/lbwin2x2.sv | 101 ++++++++++
 tb/tb_lbwin2x2.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lbwin2x2.sv
// lbwin2x2: forms registered 2x2 pixel windows from a pixel stream and its one-line-delayed copy.
//   CLK        clock, all state updates on the rising edge
//   RESET      synchronous active-high reset
//   in_data    current-line pixel (same as line buffer wdata)
//   in_en      pixel strobe (same as line buffer wen)
//   lb_rdata   line buffer read data, pixel from one line earlier
//   lb_valid   line buffer read-valid
//   win_*      window pixels: t/b = previous/current line, l/r = older/newer column
//   out_valid  one-cycle pulse per emitted window
//   out_col    column of the right-hand window column
//   out_row    current-line index of the window
//   drain_cnt  saturating count of lb_valid cycles seen while in_en=0
module lbwin2x2 #(
    parameter int LWIDTH = 8,
    parameter int CW     = 6
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [7:0]    in_data,
    input  logic          in_en,
    input  logic [7:0]    lb_rdata,
    input  logic          lb_valid,
    output logic [7:0]    win_tl,
    output logic [7:0]    win_tr,
    output logic [7:0]    win_bl,
    output logic [7:0]    win_br,
    output logic          out_valid,
    output logic [CW-1:0] out_col,
    output logic [CW-1:0] out_row,
    output logic [7:0]    drain_cnt
);
    localparam logic [CW-1:0] LAST = CW'(LWIDTH - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] col, row;
    logic          have_prev, have_prev_nx;
    logic [7:0]    prev_t, prev_b;
    logic          pair, wrap, emit;

    always_comb begin
        pair         = in_en && lb_valid;
        wrap         = in_en && col == LAST;
        emit         = pair && have_prev && col != '0;
        state_nx     = state;
        have_prev_nx = have_prev;
        if (pair) begin
            state_nx     = RUN;
            // the last column of a line can never be a left-hand column
            have_prev_nx = !wrap;
        end else if (in_en) begin
            // a sample without read data in RUN means the line buffer was drained and restarted
            if (state == RUN) begin
                state_nx     = FILL;
                have_prev_nx = 1'b0;
            end
            if (wrap) have_prev_nx = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= FILL;
            col       <= '0;
            row       <= '0;
            have_prev <= 1'b0;
            prev_t    <= '0;
            prev_b    <= '0;
            win_tl    <= '0;
            win_tr    <= '0;
            win_bl    <= '0;
            win_br    <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            out_row   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            have_prev <= have_prev_nx;
            out_valid <= emit;
            if (in_en) begin
                col <= wrap ? '0 : col + 1'b1;
                if (wrap) row <= row + 1'b1;
            end
            if (pair) begin
                prev_t <= lb_rdata;
                prev_b <= in_data;
            end
            if (emit) begin
                win_tl  <= prev_t;
                win_tr  <= lb_rdata;
                win_bl  <= prev_b;
                win_br  <= in_data;
                out_col <= col;
                out_row <= row;
            end
            if (!in_en && lb_valid && drain_cnt != 8'hff) drain_cnt <= drain_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_lbwin2x2.sv
// tb_lbwin2x2: table-driven checks of lbwin2x2 window formation, gaps, drain/restart, reset and saturation.
module tb_lbwin2x2;
    typedef struct {
        logic       en;
        logic       lv;
        logic [7:0] d;
        logic [7:0] r;
        logic       ev;
        logic [7:0] tl, tr, bl, br;
        logic [5:0] col, row;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] in_data, lb_rdata;
    logic       in_en, lb_valid;

    logic [7:0] a_tl, a_tr, a_bl, a_br, a_dc;
    logic       a_ov;
    logic [5:0] a_col, a_row;
    logic [7:0] b_tl, b_tr, b_bl, b_br, b_dc;
    logic       b_ov;
    logic [5:0] b_col, b_row;

    int checks = 0;
    int failures = 0;
    int sel = 0;
    vec_t v[$];
    logic [7:0] l_tl, l_tr, l_bl, l_br;
    logic [5:0] l_col, l_row;

    lbwin2x2 #(.LWIDTH(8), .CW(6)) dut (
        .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_en(in_en),
        .lb_rdata(lb_rdata), .lb_valid(lb_valid),
        .win_tl(a_tl), .win_tr(a_tr), .win_bl(a_bl), .win_br(a_br),
        .out_valid(a_ov), .out_col(a_col), .out_row(a_row), .drain_cnt(a_dc)
    );

    lbwin2x2 #(.LWIDTH(2), .CW(6)) dut2 (
        .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_en(in_en),
        .lb_rdata(lb_rdata), .lb_valid(lb_valid),
        .win_tl(b_tl), .win_tr(b_tr), .win_bl(b_bl), .win_br(b_br),
        .out_valid(b_ov), .out_col(b_col), .out_row(b_row), .drain_cnt(b_dc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", n, a, e);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic lv, input int d, input int r, input logic ev,
                                input int tl, input int tr, input int bl, input int br, input int col, input int row);
        vec_t x;
        x.en = en; x.lv = lv; x.d = 8'(d); x.r = 8'(r); x.ev = ev;
        x.tl = 8'(tl); x.tr = 8'(tr); x.bl = 8'(bl); x.br = 8'(br);
        x.col = 6'(col); x.row = 6'(row);
        return x;
    endfunction

    // pixel i, read data i-lw from sample lw on; window at sample i needs a pair at i-1 in the same line
    task automatic add_stream(input int n, input int lw, input int gap);
        for (int i = 0; i < n; i++) begin
            logic lv, ev;
            lv = i >= lw;
            ev = i >= lw + 1 && i % lw != 0;
            v.push_back(mk(1'b1, lv, i, lv ? i - lw : 8'hAA, ev, i - lw - 1, i - lw, i - 1, i, i % lw, i / lw));
            for (int g = 0; g < gap; g++) v.push_back(mk(1'b0, 1'b0, 8'h33, 8'h55, 1'b0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic clear_last();
        l_tl = 0; l_tr = 0; l_bl = 0; l_br = 0; l_col = 0; l_row = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1; in_en = 1'b0; lb_valid = 1'b0; in_data = 8'h00; lb_rdata = 8'h00;
        @(posedge CLK); #1;
        RESET = 1'b0;
        clear_last();
        v.delete();
    endtask

    task automatic apply(input vec_t x);
        in_en = x.en; lb_valid = x.lv; in_data = x.d; lb_rdata = x.r;
        @(posedge CLK); #1;
        if (x.ev) begin
            l_tl = x.tl; l_tr = x.tr; l_bl = x.bl; l_br = x.br; l_col = x.col; l_row = x.row;
        end
        chk("out_valid", sel ? b_ov : a_ov, x.ev);
        chk("win_tl", sel ? b_tl : a_tl, l_tl);
        chk("win_tr", sel ? b_tr : a_tr, l_tr);
        chk("win_bl", sel ? b_bl : a_bl, l_bl);
        chk("win_br", sel ? b_br : a_br, l_br);
        chk("out_col", sel ? b_col : a_col, l_col);
        chk("out_row", sel ? b_row : a_row, l_row);
    endtask

    task automatic run_all();
        foreach (v[i]) apply(v[i]);
        v.delete();
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_valid"}, a_ov, 0);
        chk({n, "_tl"}, a_tl, 0);
        chk({n, "_tr"}, a_tr, 0);
        chk({n, "_bl"}, a_bl, 0);
        chk({n, "_br"}, a_br, 0);
        chk({n, "_col"}, a_col, 0);
        chk({n, "_row"}, a_row, 0);
        chk({n, "_drain"}, a_dc, 0);
    endtask

    initial begin
        clear_last();
        do_reset();
        chk_zero("reset");

        // continuous stream: windows rows 1..2, cols 1..7
        add_stream(24, 8, 0);
        run_all();

        // gapped in_en: same windows, idle cycles hold outputs
        do_reset();
        add_stream(24, 8, 2);
        run_all();

        // drain then restart
        do_reset();
        add_stream(16, 8, 0);
        for (int i = 0; i < 6; i++) v.push_back(mk(1'b0, 1'b1, 99, 77, 1'b0, 0, 0, 0, 0, 0, 0));
        run_all();
        chk("drain_cnt6", a_dc, 6);
        v.push_back(mk(1'b1, 1'b0, 16, 0, 1'b0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1'b1, 1'b0, 17, 0, 1'b0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1'b1, 1'b1, 18, 10, 1'b0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1'b1, 1'b1, 19, 11, 1'b1, 10, 11, 18, 19, 3, 2));
        v.push_back(mk(1'b1, 1'b0, 20, 0, 1'b0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1'b1, 1'b1, 21, 13, 1'b0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1'b1, 1'b1, 22, 14, 1'b1, 13, 14, 21, 22, 6, 2));
        run_all();
        chk("drain_hold", a_dc, 6);

        // reset on a pair mid-row 1
        do_reset();
        add_stream(12, 8, 0);
        run_all();
        RESET = 1'b1; in_en = 1'b1; lb_valid = 1'b1; in_data = 8'd12; lb_rdata = 8'd4;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk_zero("midreset");
        clear_last();
        v.push_back(mk(1'b1, 1'b1, 50, 40, 1'b0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1'b1, 1'b1, 51, 41, 1'b1, 40, 41, 50, 51, 1, 0));
        run_all();

        // drain_cnt saturation
        do_reset();
        in_en = 1'b0; lb_valid = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge CLK); #1;
            if (i == 254) chk("drain_254", a_dc, 254);
            if (i == 255) chk("drain_255", a_dc, 255);
        end
        chk("drain_sat", a_dc, 255);
        chk("drain_sat_valid", a_ov, 0);

        // LWIDTH=2: one window per line at col 1
        do_reset();
        sel = 1;
        add_stream(8, 2, 0);
        run_all();
        add_stream(0, 2, 0);
        sel = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
